// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
// Contents: ALU control codes, opcode/funct constants, the state encoding,
// the packed control-word struct, and an opcode support check.
package multicycle_control_fsm_pkg;

   // ALU control codes driven towards the ALU
   localparam logic [4:0] ALU_AND = 5'b00000;
   localparam logic [4:0] ALU_OR  = 5'b00001;
   localparam logic [4:0] ALU_ADD = 5'b00010;
   localparam logic [4:0] ALU_SUB = 5'b01010;
   localparam logic [4:0] ALU_SLT = 5'b01011;
   localparam logic [4:0] ALU_NOR = 5'b11000;

   // Opcodes, instruction[31:26]
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type funct codes, instruction[5:0]
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;

   // State encoding; values are visible on the debug state output
   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_ADDI_EXEC = 4'd10,
      S_ADDI_WB   = 4'd11
   } state_e;

   // Datapath control word decoded from the current state
   typedef struct packed {
      logic       pcWrite;
      logic       IorD;
      logic       memRead;
      logic       memWrite;
      logic       irWrite;
      logic       regDst;
      logic       memToReg;
      logic       regWrite;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] pcSource;
      logic [4:0] aluControl;
      logic       illegalOp;
   } ctrl_t;

   function automatic logic opcode_supported(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
             (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Bundle between the control unit and the datapath.
// master: control unit (takes opcode/funct/zero/memReady, drives controls,
//         debug state and retireCount).
// slave : datapath side, opposite directions.
// memReady is a one-cycle completion flag: the control unit holds its memory
// request stable until it samples memReady=1 at a rising clock edge.
interface multicycle_control_fsm_if #(
   parameter int COUNT_WIDTH = 32
);
   logic [5:0]             opcode;
   logic [5:0]             funct;
   logic                   zero;
   logic                   memReady;
   logic                   pcWrite;
   logic                   IorD;
   logic                   memRead;
   logic                   memWrite;
   logic                   irWrite;
   logic                   regDst;
   logic                   memToReg;
   logic                   regWrite;
   logic                   aluSrcA;
   logic [1:0]             aluSrcB;
   logic [1:0]             pcSource;
   logic [4:0]             aluControl;
   logic                   illegalOp;
   logic [3:0]             state;
   logic [COUNT_WIDTH-1:0] retireCount;

   modport master (
      input  opcode, funct, zero, memReady,
      output pcWrite, IorD, memRead, memWrite, irWrite, regDst, memToReg,
             regWrite, aluSrcA, aluSrcB, pcSource, aluControl, illegalOp,
             state, retireCount
   );

   modport slave (
      output opcode, funct, zero, memReady,
      input  pcWrite, IorD, memRead, memWrite, irWrite, regDst, memToReg,
             regWrite, aluSrcA, aluSrcB, pcSource, aluControl, illegalOp,
             state, retireCount
   );
endinterface

// File: rtl/multicycle_control_fsm_alu_control_decode.sv
// Combinational R-type funct -> ALU control mapping.
// Ports: funct_i (instruction[5:0]), alu_ctl_o (ALU code, ADD when the
// funct is unsupported), valid_o (funct is one of the supported six).
module alu_control_decode
   import multicycle_control_fsm_pkg::*;
(
   input  logic [5:0] funct_i,
   output logic [4:0] alu_ctl_o,
   output logic       valid_o
);

   always_comb begin
      alu_ctl_o = ALU_ADD;
      valid_o   = 1'b1;
      case (funct_i)
         FN_ADD:  alu_ctl_o = ALU_ADD;
         FN_SUB:  alu_ctl_o = ALU_SUB;
         FN_AND:  alu_ctl_o = ALU_AND;
         FN_OR:   alu_ctl_o = ALU_OR;
         FN_NOR:  alu_ctl_o = ALU_NOR;
         FN_SLT:  alu_ctl_o = ALU_SLT;
         default: valid_o   = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control unit: fetch/decode/execute/memory/writeback.
// Ports: clock, reset (synchronous, active-high), bus (master modport:
// opcode/funct/zero/memReady in; datapath controls, illegalOp pulse,
// debug state and retireCount out).
// Controls are decoded combinationally from the state register because
// irWrite/pcWrite in FETCH and pcWrite in BRANCH must follow memReady/zero
// in the same cycle.
module multicycle_control_fsm
   import multicycle_control_fsm_pkg::*;
#(
   parameter int COUNT_WIDTH = 32
)
(
   input  logic                     clock,
   input  logic                     reset,
   multicycle_control_fsm_if.master bus
);

   state_e                 state_q, state_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   retire;
   logic [4:0]             fn_alu;
   logic                   fn_valid;
   ctrl_t                  ctrl;

   alu_control_decode u_alu_dec (
      .funct_i   (bus.funct),
      .alu_ctl_o (fn_alu),
      .valid_o   (fn_valid)
   );

   // Next state and retirement; every unlisted path falls back to FETCH
   always_comb begin
      state_d = S_FETCH;
      retire  = 1'b0;
      case (state_q)
         S_FETCH:  state_d = bus.memReady ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (bus.opcode)
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDI_EXEC;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_FETCH;
            endcase
         end
         S_EXECUTE:   state_d = fn_valid ? S_R_WB : S_FETCH;
         S_MEM_ADDR: begin
            if (bus.opcode == OP_LW)      state_d = S_MEM_READ;
            else if (bus.opcode == OP_SW) state_d = S_MEM_WRITE;
         end
         S_MEM_READ:  state_d = bus.memReady ? S_MEM_WB : S_MEM_READ;
         S_MEM_WRITE: begin
            if (bus.memReady) retire  = 1'b1;
            else              state_d = S_MEM_WRITE;
         end
         S_ADDI_EXEC: state_d = S_ADDI_WB;
         S_R_WB, S_MEM_WB, S_BRANCH, S_JUMP, S_ADDI_WB: retire = 1'b1;
         default:     state_d = S_FETCH;
      endcase
      count_d = retire ? count_q + COUNT_WIDTH'(1) : count_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_FETCH;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // Control word per state; anything not set here stays 0
   always_comb begin
      ctrl = '0;
      case (state_q)
         S_FETCH: begin
            ctrl.memRead    = 1'b1;
            ctrl.aluSrcB    = 2'd1;
            ctrl.aluControl = ALU_ADD;
            ctrl.irWrite    = bus.memReady;
            ctrl.pcWrite    = bus.memReady;
         end
         S_DECODE: begin
            // Branch target precompute: PC + (imm << 2)
            ctrl.aluSrcB    = 2'd3;
            ctrl.aluControl = ALU_ADD;
            ctrl.illegalOp  = !opcode_supported(bus.opcode);
         end
         S_EXECUTE: begin
            ctrl.aluSrcA    = 1'b1;
            ctrl.aluControl = fn_alu;
            ctrl.illegalOp  = !fn_valid;
         end
         S_R_WB: begin
            ctrl.regDst   = 1'b1;
            ctrl.regWrite = 1'b1;
         end
         S_MEM_ADDR, S_ADDI_EXEC: begin
            ctrl.aluSrcA    = 1'b1;
            ctrl.aluSrcB    = 2'd2;
            ctrl.aluControl = ALU_ADD;
         end
         S_MEM_READ: begin
            ctrl.IorD    = 1'b1;
            ctrl.memRead = 1'b1;
         end
         S_MEM_WB: begin
            ctrl.memToReg = 1'b1;
            ctrl.regWrite = 1'b1;
         end
         S_MEM_WRITE: begin
            ctrl.IorD     = 1'b1;
            ctrl.memWrite = 1'b1;
         end
         S_BRANCH: begin
            ctrl.aluSrcA    = 1'b1;
            ctrl.aluControl = ALU_SUB;
            ctrl.pcSource   = 2'd1;
            ctrl.pcWrite    = bus.zero;
         end
         S_JUMP: begin
            ctrl.pcSource = 2'd2;
            ctrl.pcWrite  = 1'b1;
         end
         S_ADDI_WB:   ctrl.regWrite = 1'b1;
         default:     ctrl = '0;
      endcase
   end

   assign bus.pcWrite     = ctrl.pcWrite;
   assign bus.IorD        = ctrl.IorD;
   assign bus.memRead     = ctrl.memRead;
   assign bus.memWrite    = ctrl.memWrite;
   assign bus.irWrite     = ctrl.irWrite;
   assign bus.regDst      = ctrl.regDst;
   assign bus.memToReg    = ctrl.memToReg;
   assign bus.regWrite    = ctrl.regWrite;
   assign bus.aluSrcA     = ctrl.aluSrcA;
   assign bus.aluSrcB     = ctrl.aluSrcB;
   assign bus.pcSource    = ctrl.pcSource;
   assign bus.aluControl  = ctrl.aluControl;
   assign bus.illegalOp   = ctrl.illegalOp;
   assign bus.state       = state_q;
   assign bus.retireCount = count_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm. A second instance with a 4-bit
// counter shares the same stimulus to exercise counter wrap.
module tb_multicycle_control_fsm;

   // Observed word: {state, memRead, memWrite, irWrite, pcWrite, IorD,
   // regDst, memToReg, regWrite, aluSrcA, aluSrcB, pcSource, aluControl,
   // illegalOp}
   localparam logic [22:0] P_F1     = {4'd0,  4'b1011, 4'b0000, 1'b0, 2'd1, 2'd0, 5'b00010, 1'b0};
   localparam logic [22:0] P_F0     = {4'd0,  4'b1000, 4'b0000, 1'b0, 2'd1, 2'd0, 5'b00010, 1'b0};
   localparam logic [22:0] P_DEC    = {4'd1,  4'b0000, 4'b0000, 1'b0, 2'd3, 2'd0, 5'b00010, 1'b0};
   localparam logic [22:0] P_DEC_IL = {4'd1,  4'b0000, 4'b0000, 1'b0, 2'd3, 2'd0, 5'b00010, 1'b1};
   localparam logic [22:0] P_MA     = {4'd2,  4'b0000, 4'b0000, 1'b1, 2'd2, 2'd0, 5'b00010, 1'b0};
   localparam logic [22:0] P_MR     = {4'd3,  4'b1000, 4'b1000, 1'b0, 2'd0, 2'd0, 5'b00000, 1'b0};
   localparam logic [22:0] P_MWB    = {4'd4,  4'b0000, 4'b0011, 1'b0, 2'd0, 2'd0, 5'b00000, 1'b0};
   localparam logic [22:0] P_MW     = {4'd5,  4'b0100, 4'b1000, 1'b0, 2'd0, 2'd0, 5'b00000, 1'b0};
   localparam logic [22:0] P_RWB    = {4'd7,  4'b0000, 4'b0101, 1'b0, 2'd0, 2'd0, 5'b00000, 1'b0};
   localparam logic [22:0] P_J      = {4'd9,  4'b0001, 4'b0000, 1'b0, 2'd0, 2'd2, 5'b00000, 1'b0};
   localparam logic [22:0] P_AE     = {4'd10, 4'b0000, 4'b0000, 1'b1, 2'd2, 2'd0, 5'b00010, 1'b0};
   localparam logic [22:0] P_AW     = {4'd11, 4'b0000, 4'b0001, 1'b0, 2'd0, 2'd0, 5'b00000, 1'b0};

   logic        clock;
   logic        reset;
   int          n_checks;
   int          n_fail;
   logic [31:0] exp_count;
   logic [22:0] obs;

   multicycle_control_fsm_if #(.COUNT_WIDTH(32)) bus ();
   multicycle_control_fsm_if #(.COUNT_WIDTH(4))  bus4 ();

   multicycle_control_fsm #(.COUNT_WIDTH(32)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   multicycle_control_fsm #(.COUNT_WIDTH(4)) dut4 (
      .clock (clock),
      .reset (reset),
      .bus   (bus4)
   );

   assign bus4.opcode   = bus.opcode;
   assign bus4.funct    = bus.funct;
   assign bus4.zero     = bus.zero;
   assign bus4.memReady = bus.memReady;

   assign obs = {bus.state, bus.memRead, bus.memWrite, bus.irWrite, bus.pcWrite,
                 bus.IorD, bus.regDst, bus.memToReg, bus.regWrite, bus.aluSrcA,
                 bus.aluSrcB, bus.pcSource, bus.aluControl, bus.illegalOp};

   // ---------------- clock / reset ----------------
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [22:0] exe_pat(input logic [4:0] a, input logic ill);
      return {4'd6, 8'b0000_0000, 1'b1, 2'd0, 2'd0, a, ill};
   endfunction

   function automatic logic [22:0] br_pat(input logic z);
      return {4'd8, 3'b000, z, 4'b0000, 1'b1, 2'd0, 2'd1, 5'b01010, 1'b0};
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset        = 1'b1;
      bus.memReady = 1'b0;
      bus.opcode   = 6'h3F;
      bus.funct    = 6'h00;
      bus.zero     = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      #1;
      exp_count = 0;
      n_checks++;
      if (obs !== P_F0) begin
         n_fail++;
         $display("FAIL reset_ctl: got %h expected %h", obs, P_F0);
      end
      n_checks++;
      if (bus.retireCount !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_count: got %0d expected 0", bus.retireCount);
      end
      n_checks++;
      if (bus4.retireCount !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_count4: got %0d expected 0", bus4.retireCount);
      end
   endtask

   task automatic test_rtype();
      logic [5:0]  fn_tab [6]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
      logic [4:0]  alu_tab [6] = '{5'b00010, 5'b01010, 5'b00000, 5'b00001, 5'b11000, 5'b01011};
      logic [22:0] exp_tab [5];
      for (int k = 0; k < 6; k++) begin
         bus.memReady = 1'b1;
         bus.opcode   = 6'h00;
         bus.funct    = fn_tab[k];
         #1;
         exp_tab = '{P_F1, P_DEC, exe_pat(alu_tab[k], 1'b0), P_RWB, P_F1};
         for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (obs !== exp_tab[i]) begin
               n_fail++;
               $display("FAIL rtype funct=%h step %0d: got %h expected %h", fn_tab[k], i, obs, exp_tab[i]);
            end
            if (i < 4) tick();
         end
         exp_count++;
         n_checks++;
         if (bus.retireCount !== exp_count) begin
            n_fail++;
            $display("FAIL rtype_count funct=%h: got %0d expected %0d", fn_tab[k], bus.retireCount, exp_count);
         end
      end
   endtask

   task automatic test_lw_stall();
      logic        mr_tab [9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [22:0] exp_tab [9] = '{P_F1, P_DEC, P_MA, P_MR, P_MR, P_MR, P_MR, P_MWB, P_F1};
      bus.opcode = 6'h23;
      bus.funct  = 6'h00;
      for (int i = 0; i < 9; i++) begin
         bus.memReady = mr_tab[i];
         #1;
         n_checks++;
         if (obs !== exp_tab[i]) begin
            n_fail++;
            $display("FAIL lw_stall step %0d: got %h expected %h", i, obs, exp_tab[i]);
         end
         if (i < 8) tick();
      end
      exp_count++;
      n_checks++;
      if (bus.retireCount !== exp_count) begin
         n_fail++;
         $display("FAIL lw_count: got %0d expected %0d", bus.retireCount, exp_count);
      end
   endtask

   task automatic test_sw_stall();
      logic        mr_tab [6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [22:0] exp_tab [6] = '{P_F1, P_DEC, P_MA, P_MW, P_MW, P_F1};
      bus.opcode = 6'h2B;
      for (int i = 0; i < 6; i++) begin
         bus.memReady = mr_tab[i];
         #1;
         n_checks++;
         if (obs !== exp_tab[i]) begin
            n_fail++;
            $display("FAIL sw_stall step %0d: got %h expected %h", i, obs, exp_tab[i]);
         end
         if (i < 5) tick();
      end
      exp_count++;
      n_checks++;
      if (bus.retireCount !== exp_count) begin
         n_fail++;
         $display("FAIL sw_count: got %0d expected %0d", bus.retireCount, exp_count);
      end
   endtask

   task automatic test_branch();
      logic [22:0] exp_tab [4];
      for (int z = 1; z >= 0; z--) begin
         bus.memReady = 1'b1;
         bus.opcode   = 6'h04;
         bus.zero     = z[0];
         #1;
         exp_tab = '{P_F1, P_DEC, br_pat(z[0]), P_F1};
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (obs !== exp_tab[i]) begin
               n_fail++;
               $display("FAIL beq zero=%0d step %0d: got %h expected %h", z, i, obs, exp_tab[i]);
            end
            if (i < 3) tick();
         end
         exp_count++;
         n_checks++;
         if (bus.retireCount !== exp_count) begin
            n_fail++;
            $display("FAIL beq_count zero=%0d: got %0d expected %0d", z, bus.retireCount, exp_count);
         end
      end
      bus.zero = 1'b0;
   endtask

   task automatic test_addi_jump();
      logic [22:0] addi_tab [5] = '{P_F1, P_DEC, P_AE, P_AW, P_F1};
      logic [22:0] j_tab [4]    = '{P_F1, P_DEC, P_J, P_F1};
      bus.memReady = 1'b1;
      bus.opcode   = 6'h08;
      #1;
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (obs !== addi_tab[i]) begin
            n_fail++;
            $display("FAIL addi step %0d: got %h expected %h", i, obs, addi_tab[i]);
         end
         if (i < 4) tick();
      end
      bus.opcode = 6'h02;
      #1;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (obs !== j_tab[i]) begin
            n_fail++;
            $display("FAIL jump step %0d: got %h expected %h", i, obs, j_tab[i]);
         end
         if (i < 3) tick();
      end
      exp_count += 2;
      n_checks++;
      if (bus.retireCount !== exp_count) begin
         n_fail++;
         $display("FAIL addi_jump_count: got %0d expected %0d", bus.retireCount, exp_count);
      end
   endtask

   task automatic test_illegal();
      logic [22:0] op_tab [3] = '{P_F1, P_DEC_IL, P_F1};
      logic [22:0] fn_tab [4] = '{P_F1, P_DEC, exe_pat(5'b00010, 1'b1), P_F1};
      bus.memReady = 1'b1;
      bus.opcode   = 6'h3F;
      #1;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (obs !== op_tab[i]) begin
            n_fail++;
            $display("FAIL illegal_opcode step %0d: got %h expected %h", i, obs, op_tab[i]);
         end
         if (i < 2) tick();
      end
      bus.opcode = 6'h00;
      bus.funct  = 6'h3F;
      #1;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (obs !== fn_tab[i]) begin
            n_fail++;
            $display("FAIL illegal_funct step %0d: got %h expected %h", i, obs, fn_tab[i]);
         end
         if (i < 3) tick();
      end
      n_checks++;
      if (bus.retireCount !== exp_count) begin
         n_fail++;
         $display("FAIL illegal_count: got %0d expected %0d", bus.retireCount, exp_count);
      end
   endtask

   task automatic test_reset_stall();
      bus.memReady = 1'b1;
      bus.opcode   = 6'h2B;
      tick();
      tick();
      tick();
      bus.memReady = 1'b0;
      #1;
      n_checks++;
      if (obs !== P_MW) begin
         n_fail++;
         $display("FAIL stall_mem_write: got %h expected %h", obs, P_MW);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_count = 0;
      n_checks++;
      if (obs !== P_F0) begin
         n_fail++;
         $display("FAIL reset_in_stall: got %h expected %h", obs, P_F0);
      end
      n_checks++;
      if (bus.retireCount !== 32'd0 || bus4.retireCount !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_in_stall_count: got %0d/%0d expected 0/0", bus.retireCount, bus4.retireCount);
      end
   endtask

   task automatic test_wrap();
      bus.memReady = 1'b1;
      bus.opcode   = 6'h02;
      for (int j = 0; j < 15; j++) begin
         tick();
         tick();
         tick();
      end
      n_checks++;
      if (bus4.retireCount !== 4'd15 || bus.retireCount !== 32'd15) begin
         n_fail++;
         $display("FAIL wrap_pre: got %0d/%0d expected 15/15", bus4.retireCount, bus.retireCount);
      end
      tick();
      tick();
      tick();
      n_checks++;
      if (bus4.retireCount !== 4'd0 || bus.retireCount !== 32'd16) begin
         n_fail++;
         $display("FAIL wrap: got %0d/%0d expected 0/16", bus4.retireCount, bus.retireCount);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_rtype();
      test_lw_stall();
      test_sw_stall();
      test_branch();
      test_addi_jump();
      test_illegal();
      test_reset_stall();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multi-cycle MIPS control unit that sequences fetch/decode/execute/memory/writeback. Sits directly upstream of the ALU and RegisterFile. Drives the 5-bit ALU control code, the regWrite strobe and all datapath mux selects. Stalls on a memory ready handshake and keeps a retired-instruction counter.

Parameters:
COUNT_WIDTH, 32, width of retired-instruction counter

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high; clears state and counter
opcode  input  6  instruction[31:26], taken from the instruction register
funct  input  6  instruction[5:0]
zero  input  1  ALU zero result for the current-cycle compare
memReady  input  1  memory completes the access this cycle
pcWrite  output  1  PC register enable
IorD  output  1  memory address select: 0=PC, 1=ALU out
memRead  output  1  memory read request
memWrite  output  1  memory write request
irWrite  output  1  instruction register enable
regDst  output  1  write-register select: 0=rt, 1=rd
memToReg  output  1  write-data select: 0=ALU out, 1=MDR
regWrite  output  1  RegisterFile write enable
aluSrcA  output  1  0=PC, 1=reg A
aluSrcB  output  2  0=reg B, 1=const 4, 2=sign-extended imm, 3=sign-extended imm<<2
pcSource  output  2  0=ALU result, 1=ALU out reg, 2=jump target
aluControl  output  5  ALU code: AND 00000, OR 00001, ADD 00010, SUB 01010, SLT 01011, NOR 11000
illegalOp  output  1  one-cycle pulse on unsupported opcode/funct
state  output  4  current state encoding (debug)
retireCount  output  COUNT_WIDTH  retired instructions

Behaviour:
- Single state register, updated on posedge clock. reset → FETCH, retireCount=0.
- Reset takes priority over every transition, including mid-stall.
- All outputs are decoded combinationally from state (plus memReady/zero where noted).
- Any output not listed for a state is 0.
- State encodings and actions:
  - FETCH (0): memRead=1, aluSrcA=0, aluSrcB=1, aluControl=ADD, pcSource=0; irWrite=pcWrite=memReady. Stays in FETCH while memReady=0, else → DECODE.
  - DECODE (1): aluSrcA=0, aluSrcB=3, aluControl=ADD (branch target precompute). Next state by opcode: 0x00→EXECUTE, 0x23/0x2B→MEM_ADDR, 0x04→BRANCH, 0x08→ADDI_EXEC, 0x02→JUMP. Any other opcode → FETCH with illegalOp=1 this cycle.
  - EXECUTE (6): aluSrcA=1, aluSrcB=0, aluControl from funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT. Supported funct → R_WB. Unsupported funct → FETCH, illegalOp=1, aluControl=ADD, not retired.
  - R_WB (7): regDst=1, memToReg=0, regWrite=1 → FETCH.
  - MEM_ADDR (2): aluSrcA=1, aluSrcB=2, aluControl=ADD. 0x23→MEM_READ, 0x2B→MEM_WRITE.
  - MEM_READ (3): IorD=1, memRead=1; holds while memReady=0, else → MEM_WB.
  - MEM_WB (4): regDst=0, memToReg=1, regWrite=1 → FETCH.
  - MEM_WRITE (5): IorD=1, memWrite=1; holds while memReady=0, else → FETCH.
  - BRANCH (8): aluSrcA=1, aluSrcB=0, aluControl=SUB, pcSource=1, pcWrite=zero → FETCH.
  - JUMP (9): pcSource=2, pcWrite=1 → FETCH.
  - ADDI_EXEC (10): aluSrcA=1, aluSrcB=2, aluControl=ADD → ADDI_WB.
  - ADDI_WB (11): regDst=0, memToReg=0, regWrite=1 → FETCH.
  - Encodings 12-15: unreachable; treat as FETCH next cycle.
- Latency with memReady held 1: R-type/addi 4 cycles, lw 5, sw 4, beq/j 3.
- retireCount increments by 1 on every transition into FETCH from R_WB, MEM_WB, MEM_WRITE (with memReady), BRANCH, JUMP or ADDI_WB.
- retireCount wraps modulo 2^COUNT_WIDTH. It does not increment on illegal paths.
- regWrite is asserted for exactly one cycle per writing instruction.
- memRead and memWrite are never asserted together.

Decomposition:
- Shared package: ALU control code constants, opcode/funct constants, state encoding constants.
- One sub-module, alu_control_decode: combinational funct→aluControl mapping plus a valid flag.

Test Plan:
- Reset, then memReady=1, opcode=0x00, funct=0x20 → states 0,1,6,7,0. aluControl=00010 in EXECUTE; regWrite=regDst=1 only in R_WB; retireCount 0→1.
- lw (opcode 0x23), memReady low for 3 cycles in MEM_READ → MEM_READ holds 4 cycles with IorD=memRead=1. MEM_WB has memToReg=regWrite=1. Total 8 cycles.
- beq (0x04): zero=1 → BRANCH with aluControl=01010, pcSource=1, pcWrite=1. Repeat with zero=0 → pcWrite=0. retireCount +1 each.
- opcode=0x3F → illegalOp pulses one cycle in DECODE, next state FETCH, retireCount unchanged. Same check with opcode=0, funct=0x3F in EXECUTE.
- reset asserted while stalled in MEM_WRITE (memReady=0) → next cycle state=FETCH, memWrite=0, retireCount=0.
- Preload retireCount to all-ones via 2^32-1 retirements (or COUNT_WIDTH=4 with 16 jumps) → wraps to 0.
